// File: rtl/spi_reg_master.sv
// SPI register-protocol initiator: one command byte plus one data word per frame.
// Ports: clk/rstb, ena, mode, clk_div, req/ready request, rw/addr/wdata, rdata/rdata_vld/done/busy, spi_* pins.
module spi_reg_master #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              req,
  output logic              ready,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata,
  output logic              rdata_vld,
  output logic              done,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N  = 8 + REG_W;
  localparam int EW = $clog2(2 * N + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t state, nxt_state;

  logic [DIV_W-1:0] cnt, nxt_cnt;
  logic [DIV_W-1:0] div, nxt_div;
  logic             cpol, nxt_cpol;
  logic             cpha, nxt_cpha;
  logic             rw_l, nxt_rw_l;
  logic [N-1:0]     sh, nxt_sh;
  logic [EW-1:0]    edges, nxt_edges;
  logic [REG_W-1:0] rx, nxt_rx;
  logic [REG_W-1:0] nxt_rdata;
  logic             nxt_vld, nxt_done, nxt_busy;
  logic             nxt_cs_n, nxt_sclk, nxt_mosi;
  logic             tick, lead;
  logic [N-1:0]     frame;

  assign ready = (state == IDLE) & ena;
  assign tick  = (cnt == '0);
  // even count means the next edge is odd-numbered, i.e. leading
  assign lead  = ~edges[0];
  assign frame = {rw, 7'(addr), rw ? wdata : '0};

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_div   = div;
    nxt_cpol  = cpol;
    nxt_cpha  = cpha;
    nxt_rw_l  = rw_l;
    nxt_sh    = sh;
    nxt_edges = edges;
    nxt_rx    = rx;
    nxt_rdata = rdata;
    nxt_vld   = 1'b0;
    nxt_done  = 1'b0;
    nxt_busy  = busy;
    nxt_cs_n  = spi_cs_n;
    nxt_sclk  = spi_clk;
    nxt_mosi  = spi_mosi;

    if (state != IDLE) begin
      nxt_cnt = tick ? div : cnt - DIV_W'(1);
    end

    unique case (state)
      IDLE: begin
        nxt_sclk = mode[1];
        if (req && ready) begin
          nxt_state = SETUP;
          nxt_cnt   = clk_div;
          nxt_div   = clk_div;
          nxt_cpol  = mode[1];
          nxt_cpha  = mode[0];
          nxt_rw_l  = rw;
          nxt_sh    = frame;
          nxt_edges = '0;
          nxt_cs_n  = 1'b0;
          nxt_busy  = 1'b1;
          nxt_mosi  = mode[0] ? 1'b0 : frame[N-1];
        end
      end
      SETUP: begin
        if (tick) nxt_state = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          nxt_sclk  = ~spi_clk;
          nxt_edges = edges + EW'(1);
          if (lead ^ cpha) begin
            nxt_rx = {rx[REG_W-2:0], spi_miso};
          end else begin
            // CPHA=0 already drives the MSB, so it presents the next bit
            nxt_mosi = cpha ? sh[N-1] : sh[N-2];
            nxt_sh   = {sh[N-2:0], 1'b0};
          end
          if (edges == EW'(2 * N - 1)) nxt_state = HOLD;
        end
      end
      HOLD: begin
        nxt_sclk = cpol;
        if (tick) begin
          nxt_state = GAP;
          nxt_cs_n  = 1'b1;
          nxt_done  = 1'b1;
          nxt_busy  = 1'b0;
          nxt_mosi  = 1'b0;
          if (!rw_l) begin
            nxt_rdata = rx;
            nxt_vld   = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    if (state != IDLE && !ena) begin
      nxt_state = IDLE;
      nxt_cs_n  = 1'b1;
      nxt_sclk  = cpol;
      nxt_mosi  = 1'b0;
      nxt_busy  = 1'b0;
      nxt_done  = 1'b0;
      nxt_vld   = 1'b0;
      nxt_rdata = rdata;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= '0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      rw_l      <= 1'b0;
      sh        <= '0;
      edges     <= '0;
      rx        <= '0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      div       <= nxt_div;
      cpol      <= nxt_cpol;
      cpha      <= nxt_cpha;
      rw_l      <= nxt_rw_l;
      sh        <= nxt_sh;
      edges     <= nxt_edges;
      rx        <= nxt_rx;
      rdata     <= nxt_rdata;
      rdata_vld <= nxt_vld;
      done      <= nxt_done;
      busy      <= nxt_busy;
      spi_cs_n  <= nxt_cs_n;
      spi_clk   <= nxt_sclk;
      spi_mosi  <= nxt_mosi;
    end
  end

endmodule
